split_eval_sched: RTL and testbench

- Sequencer that walks the bank of split constraint checkers (split_0 .. split_N-1) one at a time through a shared result mux.
- Drives the mux select and waits a programmable settle time for each split.
- Samples each split's x result and reports whether the whole split set is satisfied, plus the index of the first failing split.
- Sits between the solver top-level control and the split bank; the split modules themselves stay purely combinational.

---
 rtl/split_eval_sched.sv | 190 +++++++++++++++++++
 tb/tb_split_eval_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/split_eval_sched.sv
// split_eval_sched
//   Walks the bank of combinational split checkers one at a time through a
//   shared result mux. Each split stays selected for SETTLE cycles before its
//   x result is sampled. The block reports whether every split was satisfied
//   and, if not, the index of the first failing split.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request a scan (accepted only when idle)
//   abort      in   cancel a scan in progress
//   split_x    in   muxed x result of the currently selected split
//   split_sel  out  IDX_W  select for the split result mux
//   busy       out  high while a scan is in progress
//   done       out  one-cycle pulse when a scan completes (never on abort)
//   all_sat    out  1 = every split returned x=1 in the last completed scan
//   fail_idx   out  IDX_W  first split that returned x=0
//   fail_cnt   out  IDX_W+1  number of failing splits (full-scan build only)
//
// Build option
//   SPLIT_SCHED_FULLSCAN_EN : when defined, no early exit; every split is
//   scanned and the failures are counted on fail_cnt.

module split_eval_sched #(
  parameter int NUM_SPLITS = 8,
  parameter int IDX_W      = 3,
  parameter int SETTLE     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             split_x,
  output logic [IDX_W-1:0] split_sel,
  output logic             busy,
  output logic             done,
  output logic             all_sat,
  output logic [IDX_W-1:0] fail_idx
`ifdef SPLIT_SCHED_FULLSCAN_EN
  ,
  output logic [IDX_W:0]   fail_cnt
`endif
);

  // A SETTLE of 1 still needs a one-bit counter to keep the declaration legal.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] WCNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] SEL_LAST  = IDX_W'(NUM_SPLITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wcnt, wcnt_next;
  logic [IDX_W-1:0] sel_next;
  logic             busy_next;
  logic             done_next;
  logic             all_sat_next;
  logic [IDX_W-1:0] fail_idx_next;

`ifdef SPLIT_SCHED_FULLSCAN_EN
  // first_fail holds the first failing index while the scan runs, so the
  // visible fail_idx keeps the previous result until this scan completes.
  logic [IDX_W-1:0] first_fail, first_fail_next, first_val;
  logic [IDX_W:0]   fail_cnt_next, cnt_new;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wcnt       <= '0;
      split_sel  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      all_sat    <= 1'b0;
      fail_idx   <= '0;
`ifdef SPLIT_SCHED_FULLSCAN_EN
      fail_cnt   <= '0;
      first_fail <= '0;
`endif
    end else begin
      state      <= state_next;
      wcnt       <= wcnt_next;
      split_sel  <= sel_next;
      busy       <= busy_next;
      done       <= done_next;
      all_sat    <= all_sat_next;
      fail_idx   <= fail_idx_next;
`ifdef SPLIT_SCHED_FULLSCAN_EN
      fail_cnt   <= fail_cnt_next;
      first_fail <= first_fail_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    wcnt_next     = wcnt;
    sel_next      = split_sel;
    busy_next     = busy;
    done_next     = 1'b0;
    all_sat_next  = all_sat;
    fail_idx_next = fail_idx;
`ifdef SPLIT_SCHED_FULLSCAN_EN
    fail_cnt_next   = fail_cnt;
    first_fail_next = first_fail;
    cnt_new         = fail_cnt + {{IDX_W{1'b0}}, ~split_x};
    first_val       = (fail_cnt == '0 && !split_x) ? split_sel : first_fail;
`endif

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = WAIT;
          sel_next   = '0;
          wcnt_next  = '0;
          busy_next  = 1'b1;
`ifdef SPLIT_SCHED_FULLSCAN_EN
          fail_cnt_next   = '0;
          first_fail_next = '0;
`endif
        end
      end

      WAIT: begin
        if (abort) begin
          // Abort drops the previous verdict but keeps fail_idx as it was.
          state_next   = IDLE;
          busy_next    = 1'b0;
          all_sat_next = 1'b0;
          sel_next     = '0;
          wcnt_next    = '0;
        end else if (wcnt != WCNT_LAST) begin
          wcnt_next = wcnt + CNT_W'(1);
        end else begin
`ifdef SPLIT_SCHED_FULLSCAN_EN
          if (split_sel == SEL_LAST) begin
            state_next    = DONE;
            busy_next     = 1'b0;
            done_next     = 1'b1;
            fail_cnt_next = cnt_new;
            all_sat_next  = (cnt_new == '0);
            fail_idx_next = (cnt_new == '0) ? '0 : first_val;
          end else begin
            sel_next        = split_sel + IDX_W'(1);
            wcnt_next       = '0;
            fail_cnt_next   = cnt_new;
            first_fail_next = first_val;
          end
`else
          if (!split_x) begin
            // Early exit on the first failing split.
            state_next    = DONE;
            busy_next     = 1'b0;
            done_next     = 1'b1;
            all_sat_next  = 1'b0;
            fail_idx_next = split_sel;
          end else if (split_sel == SEL_LAST) begin
            state_next    = DONE;
            busy_next     = 1'b0;
            done_next     = 1'b1;
            all_sat_next  = 1'b1;
            fail_idx_next = '0;
          end else begin
            sel_next  = split_sel + IDX_W'(1);
            wcnt_next = '0;
          end
`endif
        end
      end

      DONE: begin
        state_next = IDLE;
        sel_next   = '0;
        wcnt_next  = '0;
      end

      default: begin
        state_next = IDLE;
        sel_next   = '0;
        wcnt_next  = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_split_eval_sched.sv
module tb_split_eval_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       split_x;
  logic [2:0] split_sel;
  logic       busy;
  logic       done;
  logic       all_sat;
  logic [2:0] fail_idx;
`ifdef SPLIT_SCHED_FULLSCAN_EN
  logic [3:0] fail_cnt;
  localparam logic [7:0] FAIL_MASK = 8'b0010_0100;
  localparam logic [2:0] FAIL_IDX  = 3'd2;
  localparam logic [3:0] FAIL_CNT  = 4'd2;
  localparam int         FAIL_LAT  = 16;
  localparam int         FAIL_MAX  = 7;
`else
  localparam logic [7:0] FAIL_MASK = 8'b0010_0000;
  localparam logic [2:0] FAIL_IDX  = 3'd5;
  localparam logic [3:0] FAIL_CNT  = 4'd0;
  localparam int         FAIL_LAT  = 12;
  localparam int         FAIL_MAX  = 5;
`endif

  split_eval_sched #(.NUM_SPLITS(8), .IDX_W(3), .SETTLE(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .split_x  (split_x),
    .split_sel(split_sel),
    .busy     (busy),
    .done     (done),
    .all_sat  (all_sat),
    .fail_idx (fail_idx)
`ifdef SPLIT_SCHED_FULLSCAN_EN
    ,
    .fail_cnt (fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Split bank model: a split fails when its bit in fail_mask is set.
  logic [7:0] fail_mask;
  assign split_x = ~fail_mask[split_sel];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       all_sat;
    logic [2:0] idx;
    logic [3:0] cnt;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor: each done pulse pops one expected scan result.
  logic prev_done = 1'b0;
  int   max_sel   = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy && int'(split_sel) > max_sel) max_sel = int'(split_sel);
      if (done) begin
        chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("all_sat", {31'd0, all_sat}, {31'd0, e.all_sat});
          chk("fail_idx", {29'd0, fail_idx}, {29'd0, e.idx});
`ifdef SPLIT_SCHED_FULLSCAN_EN
          chk("fail_cnt", {28'd0, fail_cnt}, {28'd0, e.cnt});
`endif
          $display("scan done: cyc=%0d all_sat=%0d fail_idx=%0d", cyc, all_sat, fail_idx);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic run_scan(input logic [7:0] mask, input logic ea, input logic [2:0] ei,
                          input logic [3:0] ec, input int lat, input bit poke);
    exp_t e;
    int   t;
    @(negedge clk);
    fail_mask = mask;
    start     = 1'b1;
    e.all_sat = ea;
    e.idx     = ei;
    e.cnt     = ec;
    e.cyc     = cyc + 1 + lat;
    sb.push_back(e);
    max_sel   = 0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("sel_at_start", {29'd0, split_sel}, 32'd0);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("scan_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("sel_back_to_0", {29'd0, split_sel}, 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_sel", {29'd0, split_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_all_sat", {31'd0, all_sat}, 32'd0);
    chk("rst_fail_idx", {29'd0, fail_idx}, 32'd0);
`ifdef SPLIT_SCHED_FULLSCAN_EN
    chk("rst_fail_cnt", {28'd0, fail_cnt}, 32'd0);
`endif
  endtask

  task automatic wait_sel(input logic [2:0] s);
    int t;
    t = 0;
    while (split_sel != s && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_sel", {29'd0, split_sel}, {29'd0, s});
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    fail_mask = 8'd0;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: nothing moves.
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_sel", {29'd0, split_sel}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    // All pass: 16 busy cycles, split_sel reaches 7.
    run_scan(8'd0, 1'b1, 3'd0, 4'd0, 16, 1'b0);
    chk("allpass_max_sel", max_sel, 32'd7);

    // Failing split(s).
    run_scan(FAIL_MASK, 1'b0, FAIL_IDX, FAIL_CNT, FAIL_LAT, 1'b0);
    chk("fail_max_sel", max_sel, FAIL_MAX);

    // All pass with a stray start while busy: timing unchanged.
    run_scan(8'd0, 1'b1, 3'd0, 4'd0, 16, 1'b1);

    // Abort at split_sel=3.
    @(negedge clk);
    fail_mask = 8'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sel(3'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_all_sat", {31'd0, all_sat}, 32'd0);
    chk("abort_fail_idx", {29'd0, fail_idx}, 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_stays_idle", {31'd0, busy}, 32'd0);

    // start+abort together in IDLE is ignored.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("start_abort_idle", {31'd0, busy}, 32'd0);

    // Fresh scan after abort starts from split 0.
    run_scan(FAIL_MASK, 1'b0, FAIL_IDX, FAIL_CNT, FAIL_LAT, 1'b0);

    // Reset mid-scan at split_sel=4: outputs clear before the next edge.
    @(negedge clk);
    fail_mask = 8'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sel(3'd4);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    run_scan(8'd0, 1'b1, 3'd0, 4'd0, 16, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
